matrix_seq_ctrl: RTL and testbench

- Row-serial sequencer for the fixed-point matrix-vector multiply.
- Loads vector A once over a stream, then consumes matrix B one element per beat, row by row.
- Each product is shifted right by DATA_SIZE and accumulated per row; the row sum is saturated and each output element is emitted over a valid/ready handshake.
- Replaces the fully parallel array where area matters; sits between the operand DMA and the result buffer.

---
 rtl/matrix_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_matrix_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_seq_ctrl.sv
// Row-serial matrix-vector sequencer: loads vector A, streams matrix B row by row,
// emits one saturated result per row. Optional abort input: define MATRIX_SEQ_ABORT_EN.
module matrix_seq_ctrl #(
  parameter int DATA_SIZE   = 8,
  parameter int COLUMN_SIZE = 64,
  parameter int ROW_SIZE    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
`ifdef MATRIX_SEQ_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy,
  output logic                          done,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [DATA_SIZE-1:0]          a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [DATA_SIZE-1:0]          b_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_SIZE-1:0]          out_data,
  output logic [$clog2(ROW_SIZE)-1:0]   out_index
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_LOAD_A | accepting vector A beats
  // S_RUN    | accepting B beats of the current row, accumulating
  // S_EMIT   | presenting the saturated row result
  // S_DONE   | one-cycle done pulse, then back to idle

  localparam int CW = $clog2(COLUMN_SIZE);
  localparam int RW = $clog2(ROW_SIZE);
  localparam int AW = DATA_SIZE + CW;
  localparam int PW = 2 * DATA_SIZE;
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_RUN, S_EMIT, S_DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic [AW-1:0]          acc_q;
  logic [AW-1:0]          acc_d;
  logic [DATA_SIZE-1:0]   a_mem_q [COLUMN_SIZE];
  logic                   busy_q, done_q, a_ready_q, b_ready_q, out_valid_q;
  logic [DATA_SIZE-1:0]   out_data_q;
  logic [RW-1:0]          out_index_q;
  logic [PW-1:0]          prod;
  logic [DATA_SIZE-1:0]   sat_d;
  logic                   abort_w;

`ifdef MATRIX_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Keep only the upper half of the full-width product (truncation).
  assign prod  = PW'(a_mem_q[col_q]) * PW'(b_data);
  assign acc_d = acc_q + AW'(prod >> DATA_SIZE);
  assign sat_d = (|acc_d[AW-1:DATA_SIZE]) ? '1 : acc_d[DATA_SIZE-1:0];

  always_ff @(posedge clock) begin
    if (state_q == S_LOAD_A && a_valid && !abort_w) begin
      a_mem_q[col_q] <= a_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (abort_w && state_q != S_IDLE)) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= S_LOAD_A;
            busy_q    <= 1'b1;
            a_ready_q <= 1'b1;
            col_q     <= '0;
            row_q     <= '0;
          end
        end
        S_LOAD_A: begin
          if (a_valid) begin
            if (col_q == COL_LAST) begin
              state_q   <= S_RUN;
              a_ready_q <= 1'b0;
              b_ready_q <= 1'b1;
              col_q     <= '0;
              acc_q     <= '0;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (b_valid) begin
            acc_q <= acc_d;
            if (col_q == COL_LAST) begin
              state_q     <= S_EMIT;
              b_ready_q   <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= sat_d;
              out_index_q <= row_q;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (row_q == ROW_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              b_ready_q <= 1'b1;
              row_q     <= row_q + 1'b1;
              col_q     <= '0;
              acc_q     <= '0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_ready   = a_ready_q;
  assign b_ready   = b_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Self-checking bench for matrix_seq_ctrl (DATA_SIZE=8, COLUMN_SIZE=4, ROW_SIZE=2):
// fixed vector table, random jobs against a sum-of-products model, and corner sequences.
module tb_matrix_seq_ctrl;
  localparam int DS = 8;
  localparam int NC = 4;
  localparam int NR = 2;
  localparam int MIN_JOB = NC + NR * (NC + 1) + 1;

  logic          clock = 1'b0;
  logic          reset, start, abort;
  logic          busy, done, a_valid, a_ready, b_valid, b_ready, out_valid, out_ready;
  logic [DS-1:0] a_data, b_data, out_data;
  logic          out_index;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [NC-1:0][DS-1:0]    a;
    logic [NC*NR-1:0][DS-1:0] b;
    logic [NR-1:0][DS-1:0]    ex;
  } vec_t;

  vec_t tbl [4];

  matrix_seq_ctrl #(.DATA_SIZE(DS), .COLUMN_SIZE(NC), .ROW_SIZE(NR)) dut (
    .clock(clock), .reset(reset), .start(start),
`ifdef MATRIX_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each row result is the sum of (a*b)/256 over the row, clipped to 255.
  task automatic model(input logic [NC-1:0][DS-1:0] a, input logic [NC*NR-1:0][DS-1:0] b,
                       output logic [NR-1:0][DS-1:0] r);
    for (int rw = 0; rw < NR; rw++) begin
      int s;
      s = 0;
      for (int c = 0; c < NC; c++) s += (int'(a[c]) * int'(b[rw*NC + c])) / 256;
      r[rw] = (s > 255) ? 8'hFF : DS'(s);
    end
  endtask

  // kill_mode: 0 none, 1 reset on B beat number kill_at, 2 abort in EMIT of row kill_at
  task automatic run_job(input vec_t v, input int gap, input int stall0, input bit poke,
                         input int kill_mode, input int kill_at);
    int idx, budget, t0;
    logic r;
    bit va;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", busy, 1);
    chk("a_ready_load", a_ready, 1);
    idx = 0;
    budget = 0;
    while (idx < NC && budget < 200) begin
      r = a_ready;
      va = ($urandom_range(99) >= gap);
      a_valid = va;
      a_data = va ? v.a[idx] : DS'($urandom);
      step();
      if (va && r) idx++;
      budget++;
    end
    a_valid = 1'b0;
    if (idx < NC) begin
      chk("load_a_timeout", idx, NC);
      return;
    end
    for (int row = 0; row < NR; row++) begin
      idx = 0;
      budget = 0;
      while (idx < NC && budget < 200) begin
        bit kill;
        kill = (kill_mode == 1) && (row * NC + idx == kill_at);
        r = b_ready;
        va = kill || ($urandom_range(99) >= gap);
        b_valid = va;
        b_data = va ? v.b[row*NC + idx] : DS'($urandom);
        if (kill) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          b_valid = 1'b0;
          chk("rst_busy", busy, 0);
          chk("rst_out_valid", out_valid, 0);
          chk("rst_done", done, 0);
          chk("rst_b_ready", b_ready, 0);
          for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_done", done, 0);
          end
          return;
        end
        if (poke && row == 0 && idx == 1) start = 1'b1;
        step();
        start = 1'b0;
        if (va && r) idx++;
        chk("a_ready_in_run", a_ready, 0);
        budget++;
      end
      b_valid = 1'b0;
      if (idx < NC) begin
        chk("load_b_timeout", idx, NC);
        return;
      end
      chk("out_valid_after_row", out_valid, 1);
      if (row == 0) begin
        for (int s = 0; s < stall0; s++) begin
          out_ready = 1'b0;
          step();
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_data", out_data, v.ex[0]);
          chk("stall_out_index", out_index, 0);
          chk("stall_b_ready", b_ready, 0);
        end
      end
`ifdef MATRIX_SEQ_ABORT_EN
      if (kill_mode == 2 && row == kill_at) begin
        out_ready = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_b_ready", b_ready, 0);
        chk("abort_done", done, 0);
        for (int k = 0; k < 3; k++) begin
          step();
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
        end
        return;
      end
`endif
      chk("out_index", out_index, row);
      chk("out_data", out_data, v.ex[row]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      if (row < NR - 1) begin
        chk("b_ready_next_row", b_ready, 1);
        chk("done_early", done, 0);
      end
    end
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    if (gap == 0 && stall0 == 0) chk("job_cycles", cyc - t0 + 1, MIN_JOB);
    if (poke) start = 1'b1;
    step();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("a_ready_idle", a_ready, 0);
  endtask

  initial begin
    vec_t rv;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;

    tbl[0].a = {NC{8'h80}};
    tbl[0].b = {{NC{8'h40}}, {NC{8'h80}}};
    tbl[0].ex = {8'h80, 8'hFF};
    tbl[1].a = {NC{8'hFF}};
    tbl[1].b = {{NC{8'hFF}}, {NC{8'h01}}};
    tbl[1].ex = {8'hFF, 8'h00};
    tbl[2].a = {8'd4, 8'd3, 8'd2, 8'd1};
    tbl[2].b = {8'h40, 8'h30, 8'h20, 8'h10, {NC{8'hFF}}};
    tbl[2].ex = {8'h01, 8'h06};
    tbl[3].a = {8'h80, 8'h40, 8'h20, 8'h10};
    tbl[3].b = {{NC{8'hFF}}, {NC{8'h80}}};
    tbl[3].ex = {8'hEC, 8'h78};

    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_a_ready", a_ready, 0);
    chk("reset_b_ready", b_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_index", out_index, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_job(tbl[i], 0, 0, 1'b0, 0, 0);

    run_job(tbl[0], 40, 5, 1'b0, 0, 0);
    run_job(tbl[3], 0, 0, 1'b1, 0, 0);
    step();
    chk("start_in_done_ignored", busy, 0);

    run_job(tbl[1], 0, 0, 1'b0, 1, NC + 2);
    run_job(tbl[2], 0, 0, 1'b0, 0, 0);

    for (int j = 0; j < 6; j++) begin
      for (int c = 0; c < NC; c++) rv.a[c] = DS'($urandom);
      for (int c = 0; c < NC * NR; c++) rv.b[c] = DS'($urandom);
      model(rv.a, rv.b, rv.ex);
      run_job(rv, 25, $urandom_range(3), 1'b0, 0, 0);
    end

`ifdef MATRIX_SEQ_ABORT_EN
    run_job(tbl[0], 0, 0, 1'b0, 2, 0);
    abort = 1'b1;
    step();
    chk("abort_in_idle", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", a_ready, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    run_job(tbl[3], 0, 0, 1'b0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
